seqdec_ctrl: RTL and testbench

SEQDEC_CTRL -- requirements
Module: seqdec_ctrl

---
 rtl/seqdec_ctrl.sv | 121 ++++++++++++
 tb/tb_seqdec_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seqdec_ctrl.sv
// Serial pattern detector: after Start, fills a PAT_W-bit window from Inp, then counts
// (possibly overlapping) window matches until the captured threshold is reached.
module seqdec_ctrl #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PAT_W-1:0] Pattern,
    input  logic [CNT_W-1:0] Threshold,
    input  logic             Inp,
    input  logic             Abort,
    input  logic             Ack,
    output logic             Busy,
    output logic             Match,
    output logic             Done,
    output logic [CNT_W-1:0] MatchCnt
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDetect, StDone} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   shreg_q, shreg_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               match_q, match_d;
    logic [PAT_W-1:0]   window;
    logic [CNT_W-1:0]   cnt_inc;
    logic               win_valid;
    logic               hit;

    always_comb begin
        window    = (shreg_q << 1) | PAT_W'(Inp);
        cnt_inc   = cnt_q + CNT_W'(1);
        // Stale bits from an earlier run are never compared: the window only counts
        // once PAT_W fresh bits have been shifted in.
        win_valid = (state_q == StDetect) || ((state_q == StFill) && (fill_q == FILL_LAST));
        hit       = win_valid && (window == pat_q);
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pat_d   = pat_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        match_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (Start && (Threshold != '0)) begin
                    pat_d   = Pattern;
                    thr_d   = Threshold;
                    shreg_d = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill, StDetect: begin
                if (Abort) begin
                    state_d = StIdle;
                end else begin
                    shreg_d = window;
                    if (state_q == StFill) begin
                        fill_d = fill_q + FILL_W'(1);
                        if (fill_q == FILL_LAST) begin
                            state_d = StDetect;
                        end
                    end
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == thr_q) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (Ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            pat_q   <= '0;
            thr_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            pat_q   <= pat_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign Busy     = (state_q == StFill) || (state_q == StDetect);
    assign Done     = (state_q == StDone);
    assign Match    = match_q;
    assign MatchCnt = cnt_q;

endmodule

// File: tb/tb_seqdec_ctrl.sv
// Scoreboard bench for seqdec_ctrl: a bit-history reference model predicts each cycle's
// outputs, a separate monitor pops and compares them after every rising edge.
module tb_seqdec_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic [PAT_W-1:0] Pattern = '0;
    logic [CNT_W-1:0] Threshold = '0;
    logic             Inp = 1'b0;
    logic             Abort = 1'b0;
    logic             Ack = 1'b0;
    logic             Busy;
    logic             Match;
    logic             Done;
    logic [CNT_W-1:0] MatchCnt;

    seqdec_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Pattern(Pattern), .Threshold(Threshold),
        .Inp(Inp), .Abort(Abort), .Ack(Ack), .Busy(Busy), .Match(Match), .Done(Done),
        .MatchCnt(MatchCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit busy;
        bit match;
        bit done;
        int cnt;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;

    // Reference model: run flags, captured settings and the raw history of sampled bits.
    bit               m_active = 1'b0;
    bit               m_done = 1'b0;
    bit               m_match = 1'b0;
    int               m_cnt = 0;
    int               m_nbits = 0;
    logic [PAT_W-1:0] m_pat = '0;
    int               m_thr = 0;
    bit               hist[$];

    logic [PAT_W-1:0] tb_pat = '0;
    logic [CNT_W-1:0] tb_thr = '0;

    task automatic model_step(input bit rst, input bit st, input bit in, input bit ab,
                              input bit ak);
        int w;
        m_match = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_cnt    = 0;
            m_nbits  = 0;
            m_pat    = '0;
            m_thr    = 0;
            hist.delete();
        end else if (m_active) begin
            if (ab) begin
                m_active = 1'b0;
            end else begin
                hist.push_back(in);
                if (hist.size() > PAT_W) void'(hist.pop_front());
                m_nbits++;
                if (m_nbits >= PAT_W) begin
                    w = 0;
                    foreach (hist[i]) w = (w * 2) + int'(hist[i]);
                    if (w == int'(m_pat)) begin
                        m_match = 1'b1;
                        m_cnt++;
                        if (m_cnt == m_thr) begin
                            m_active = 1'b0;
                            m_done   = 1'b1;
                        end
                    end
                end
            end
        end else if (m_done) begin
            if (ak) m_done = 1'b0;
        end else if (st && tb_thr != 0) begin
            m_pat    = tb_pat;
            m_thr    = int'(tb_thr);
            m_cnt    = 0;
            m_nbits  = 0;
            hist.delete();
            m_active = 1'b1;
        end
    endtask

    task automatic tick(input bit rst, input bit st, input bit in, input bit ab, input bit ak);
        exp_t e;
        @(negedge Clk);
        Reset     = rst;
        Start     = st;
        Inp       = in;
        Abort     = ab;
        Ack       = ak;
        Pattern   = tb_pat;
        Threshold = tb_thr;
        model_step(rst, st, in, ab, ak);
        e.busy  = m_active;
        e.match = m_match;
        e.done  = m_done;
        e.cnt   = m_cnt;
        e.cyc   = cyc_n;
        cyc_n++;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) tick(1'b0, 1'b0, bits[i], 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_start(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t);
        tb_pat = p;
        tb_thr = t;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a registered output set; compare to the queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (Busy !== e.busy) begin
                    failures++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, Busy, e.busy);
                end
                checks++;
                if (Match !== e.match) begin
                    failures++;
                    $display("FAIL match cyc=%0d got=%b exp=%b", e.cyc, Match, e.match);
                end
                checks++;
                if (Done !== e.done) begin
                    failures++;
                    $display("FAIL done cyc=%0d got=%b exp=%b", e.cyc, Done, e.done);
                end
                checks++;
                if ($isunknown(MatchCnt) || int'(MatchCnt) != e.cnt) begin
                    failures++;
                    $display("FAIL match_cnt cyc=%0d got=%0d exp=%0d", e.cyc, MatchCnt, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        int  rpos;
        bit  in;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Single match ends run, then Ack.
        run_start(8'h52, 4'd1);
        send_bits(16'h0052, 8);
        idle(1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Overlapping matches.
        run_start(8'hAA, 4'd2);
        send_bits(16'h02AA, 10);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // All-zero pattern must not match on reset-cleared bits.
        run_start(8'h00, 4'd1);
        send_bits(16'h0000, 8);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Threshold zero ignored, then Start during a run must not recapture.
        run_start(8'h52, 4'd0);
        idle(1);
        run_start(8'h52, 4'd3);
        tb_pat = 8'hFF;
        tb_thr = 4'd1;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'h0052, 7);
        idle(2);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1);

        // Reset in the middle of a detect phase.
        run_start(8'h52, 4'd3);
        send_bits(16'h0052, 8);
        send_bits(16'h0002, 2);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Abort on the same edge as a completing match.
        run_start(8'h52, 4'd1);
        send_bits(16'h0029, 7);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Start+Ack together in DONE, then Start alone.
        run_start(8'h52, 4'd1);
        send_bits(16'h0052, 8);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);
        run_start(8'h52, 4'd1);
        idle(3);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized phase, biased toward feeding the captured pattern so matches occur.
        rpos = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0: tb_pat = 8'h52;
                    1: tb_pat = 8'hAA;
                    2: tb_pat = 8'h00;
                    3: tb_pat = 8'hFF;
                    default: tb_pat = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 9) == 0) tb_thr = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 9) != 0) in = m_pat[PAT_W - 1 - (rpos % PAT_W)];
            else in = 1'($urandom);
            rpos++;
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), in,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(2);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
